sample_capture_fifo: RTL and testbench

SAMPLE_CAPTURE_FIFO -- requirements
Module: sample_capture_fifo

---
 rtl/sample_capture_fifo.sv | 108 ++++++++++
 tb/tb_sample_capture_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_capture_fifo                                                      |
// | Captures strobed samples into a FWFT FIFO, streamed out as AXI-S packets.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sample_capture_fifo #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16,
  parameter int PKT_LEN      = 8,
  parameter int CTRL_RST_BIT = 0,
  parameter int CTRL_EN_BIT  = 1
) (
  input  logic                     clk,
  input  logic                     a_rst_n,
  input  logic                     i_sample_en,
  input  logic [DATA_W-1:0]        i_sample_data,
  input  logic [31:0]              i_ctrl_reg,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     o_overflow,
  output logic [15:0]              o_drop_cnt,
  output logic [$clog2(DEPTH):0]   o_fill_level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_bw = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_aw:0]   c_depth    = (c_aw+1)'(DEPTH);
  localparam logic [c_bw-1:0] c_last_bt  = c_bw'(PKT_LEN - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_fill;
  logic [c_bw-1:0]   r_beat_cnt;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic w_flush;
  logic w_enable;
  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_pop;

  assign w_flush  = i_ctrl_reg[CTRL_RST_BIT];
  assign w_enable = i_ctrl_reg[CTRL_EN_BIT];
  // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
  assign w_full   = (r_fill == c_depth);
  assign w_push   = i_sample_en && w_enable && !w_flush && !w_full;
  assign w_drop   = i_sample_en && w_enable && !w_flush && w_full;
  assign w_pop    = m_axis_tvalid && m_axis_tready && !w_flush;

  assign m_axis_tvalid = (r_fill != '0);
  assign m_axis_tdata  = r_mem[r_rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && (r_beat_cnt == c_last_bt);
  assign o_overflow    = r_overflow;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_fill_level  = r_fill;

  // Storage carries no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_sample_data;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_beat_cnt <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_beat_cnt <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + c_aw'(1);
        r_beat_cnt <= (r_beat_cnt == c_last_bt) ? '0 : r_beat_cnt + c_bw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (c_aw+1)'(1);
        2'b01:   r_fill <= r_fill - (c_aw+1)'(1);
        default: r_fill <= r_fill;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_capture_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sample_capture_fifo                                                   |
// | Directed stimulus with a queue scoreboard and a negedge stream monitor.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sample_capture_fifo;

  localparam int c_pkt = 8;

  logic        clk = 1'b0;
  logic        a_rst_n;
  logic        i_sample_en;
  logic [15:0] i_sample_data;
  logic [31:0] i_ctrl_reg;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;
  logic [4:0]  o_fill_level;

  int          vectors     = 0;
  int          miscompares = 0;
  int          last_cnt    = 0;
  int          beat        = 0;
  logic [15:0] exp_q [$];

  sample_capture_fifo dut (
    .clk           (clk),
    .a_rst_n       (a_rst_n),
    .i_sample_en   (i_sample_en),
    .i_sample_data (i_sample_data),
    .i_ctrl_reg    (i_ctrl_reg),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_overflow    (o_overflow),
    .o_drop_cnt    (o_drop_cnt),
    .o_fill_level  (o_fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    i_ctrl_reg = 32'h3;
    exp_q.delete();
    cyc();
    i_ctrl_reg = 32'h2;
  endtask

  task automatic wait_empty(input int max_cycles);
    int n;
    n = 0;
    while (o_fill_level != 0 && n < max_cycles) begin
      cyc();
      n++;
    end
    chk("drain_timeout", {31'd0, (o_fill_level != 0)}, 32'd0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // Stream monitor: decides handshakes on the negedge, where inputs and outputs are settled.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    logic [15:0] exp_d;
    if (!a_rst_n) begin
      beat       = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_tlast", m_axis_tlast, prev_last);
      end
      if (i_ctrl_reg[0]) begin
        beat       = 0;
        prev_stall = 1'b0;
      end else begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h, expected no beat at %0t", m_axis_tdata, $time);
          end else begin
            exp_d = exp_q.pop_front();
            chk("tdata", m_axis_tdata, exp_d);
            chk("tlast", m_axis_tlast, (beat == c_pkt - 1));
          end
          if (m_axis_tlast) last_cnt++;
          beat = (beat == c_pkt - 1) ? 0 : beat + 1;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc0;
    a_rst_n       = 1'b0;
    i_sample_en   = 1'b0;
    i_sample_data = '0;
    i_ctrl_reg    = 32'h2;
    m_axis_tready = 1'b1;
    cyc();
    cyc();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_drop_cnt", o_drop_cnt, 0);
    chk("rst_fill", o_fill_level, 0);

    // Release reset with a strobe already pending: first edge must write it.
    a_rst_n       = 1'b1;
    i_sample_en   = 1'b1;
    i_sample_data = 16'h1234;
    exp_q.push_back(16'h1234);
    cyc();
    i_sample_en = 1'b0;
    chk("lat_tvalid", m_axis_tvalid, 1);
    chk("lat_tdata", m_axis_tdata, 16'h1234);
    chk("lat_fill", o_fill_level, 1);
    cyc();
    chk("lat_fill_after_pop", o_fill_level, 0);
    chk("lat_tvalid_after_pop", m_axis_tvalid, 0);
    flush();

    // Packetisation: 24 samples, one every 4 cycles.
    lc0 = last_cnt;
    for (int i = 0; i < 24; i++) begin
      i_sample_en   = 1'b1;
      i_sample_data = 16'(i);
      exp_q.push_back(16'(i));
      cyc();
      i_sample_en = 1'b0;
      repeat (3) cyc();
    end
    wait_empty(20);
    chk("pkt_tlast_count", last_cnt - lc0, 3);

    // Overflow: 20 strobes into a stalled 16-deep FIFO.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_sample_en   = 1'b1;
      i_sample_data = 16'h0100 + 16'(i);
      if (i < 16) exp_q.push_back(16'h0100 + 16'(i));
      cyc();
    end
    i_sample_en = 1'b0;
    chk("ovf_fill", o_fill_level, 16);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_drop_cnt", o_drop_cnt, 4);

    // Full FIFO with a same-cycle pop still drops the strobe.
    i_sample_en   = 1'b1;
    i_sample_data = 16'hDEAD;
    m_axis_tready = 1'b1;
    cyc();
    i_sample_en = 1'b0;
    chk("fullpop_drop_cnt", o_drop_cnt, 5);
    chk("fullpop_fill", o_fill_level, 15);
    chk("fullpop_overflow", o_overflow, 1);
    lc0 = last_cnt;
    wait_empty(40);
    chk("ovf_tlast_count", last_cnt - lc0, 2);

    // Flush mid-packet: 11 popped (beat 3), 5 queued, overflow set.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_sample_en   = 1'b1;
      i_sample_data = 16'h0200 + 16'(i);
      if (i < 16) exp_q.push_back(16'h0200 + 16'(i));
      cyc();
    end
    i_sample_en   = 1'b0;
    m_axis_tready = 1'b1;
    repeat (11) cyc();
    m_axis_tready = 1'b0;
    chk("pre_flush_fill", o_fill_level, 5);
    chk("pre_flush_overflow", o_overflow, 1);
    flush();
    chk("flush_fill", o_fill_level, 0);
    chk("flush_tvalid", m_axis_tvalid, 0);
    chk("flush_overflow", o_overflow, 0);
    chk("flush_drop_cnt", o_drop_cnt, 0);
    lc0 = last_cnt;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_sample_en   = 1'b1;
      i_sample_data = 16'h0300 + 16'(i);
      exp_q.push_back(16'h0300 + 16'(i));
      cyc();
    end
    i_sample_en = 1'b0;
    wait_empty(20);
    chk("post_flush_tlast_count", last_cnt - lc0, 1);

    // Random backpressure, then async reset mid-stream.
    for (int i = 0; i < 12; i++) begin
      i_sample_en   = 1'b1;
      i_sample_data = 16'h0400 + 16'(i);
      exp_q.push_back(16'h0400 + 16'(i));
      m_axis_tready = 1'($urandom_range(0, 1));
      cyc();
      i_sample_en   = 1'b0;
      m_axis_tready = 1'($urandom_range(0, 1));
      cyc();
    end
    m_axis_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_sample_en   = 1'b1;
      i_sample_data = 16'h0500 + 16'(i);
      exp_q.push_back(16'h0500 + 16'(i));
      cyc();
    end
    i_sample_en = 1'b0;
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #2;
    a_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_tlast", m_axis_tlast, 0);
    chk("arst_overflow", o_overflow, 0);
    chk("arst_drop_cnt", o_drop_cnt, 0);
    chk("arst_fill", o_fill_level, 0);
    cyc();
    a_rst_n       = 1'b1;
    m_axis_tready = 1'b1;
    i_sample_en   = 1'b1;
    i_sample_data = 16'h0ABC;
    exp_q.push_back(16'h0ABC);
    cyc();
    i_sample_en = 1'b0;
    chk("post_rst_tdata", m_axis_tdata, 16'h0ABC);
    wait_empty(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
